// File: rtl/traffic_pkg.sv
// Shared constants for the traffic controller front end.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: pin channel map for the conditioned inputs and default
// debounce timing (1 ms tick at 50 MHz, 10 ms stability window).
package traffic_pkg;

  localparam int CH_SET    = 0;
  localparam int CH_RST    = 1;
  localparam int CH_PQM    = 2;
  localparam int CH_PQC    = 3;
  localparam int CH_CM     = 4;
  localparam int CH_CC     = 5;
  localparam int CH_ONLINE = 6;
  localparam int CH_PEAK   = 7;

  localparam int TICK_DIV_DEFAULT     = 50000;
  localparam int STABLE_TICKS_DEFAULT = 10;

endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-flop synchroniser, tick-sampled stability counter,
// debounced level with registered rise/fall pulses and a press toggle.
// Latency: 2 clk to sync, then STABLE_TICKS mismatched ticks to accept.
// Backpressure: none; free-running, outputs are levels and 1-cycle pulses.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   raw           asynchronous pin input
//   tick          shared debounce sampling strobe (1 cycle)
//   level         debounced level
//   rise, fall    1-cycle pulses, high in the first cycle of the new level
//   toggle        flips on every accepted rise
module debounce_ch
  import traffic_pkg::*;
#(
  parameter int   STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int            CW   = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic          accept;

  assign mismatch = sync_q[1] ^ level;
  // Final tick of the window: take the new level on this edge.
  assign accept   = mismatch && tick && (cnt == LAST);

  // Sync flops start at the reset level so release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Any cycle where the input agrees with the level clears the count, so a
  // bounce back restarts the window. The count tops out at LAST and is
  // cleared on accept, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!mismatch) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= accept ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
      toggle <= 1'b0;
    end else begin
      rise <= accept &&  sync_q[1];
      fall <= accept && !sync_q[1];
      if (accept) begin
        level <= sync_q[1];
      end
      if (accept && sync_q[1]) begin
        toggle <= ~toggle;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Board pin front end: synchronise and debounce NUM_CH pushbutton/switch
// inputs against one shared prescaled tick.
// Latency: 2 + (STABLE_TICKS-1)*TICK_DIV + 1 .. 2 + STABLE_TICKS*TICK_DIV clk.
// Backpressure: none; free-running, outputs are levels and 1-cycle pulses.
// Ports:
//   clk, rst   system clock, asynchronous active-high power-on reset
//              (the traffic rst button is raw_in[CH_RST], not this)
//   raw_in     asynchronous pin inputs, one bit per channel
//   level_o    debounced levels
//   rise_o     1-cycle pulse per channel on a 0->1 change of level_o
//   fall_o     1-cycle pulse per channel on a 1->0 change of level_o
//   toggle_o   per-channel toggle, flips on each rise
//   tick_o     debounce tick, one cycle every TICK_DIV cycles
module input_conditioner
  import traffic_pkg::*;
#(
  parameter int                NUM_CH       = 8,
  parameter int                TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int                STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter logic [NUM_CH-1:0] RESET_LEVEL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] toggle_o,
  output logic              tick_o
);

  localparam int            PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;

  // Free-running prescaler; never restarted by input activity. Reset value
  // 0 keeps tick_o low during reset because TICK_DIV >= 2.
  assign tick_o = (pre_cnt == P_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= tick_o ? '0 : pre_cnt + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_VAL    (RESET_LEVEL[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_in[i]),
      .tick   (tick_o),
      .level  (level_o[i]),
      .rise   (rise_o[i]),
      .fall   (fall_o[i]),
      .toggle (toggle_o[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with TICK_DIV=4, STABLE_TICKS=3, NUM_CH=8.
module tb_input_conditioner;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw_in = '0;
  logic [7:0] level_o, rise_o, fall_o, toggle_o;
  logic       tick_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse activity seen at the falling edge, cleared by the test body.
  logic [7:0] rise_or = '0, fall_or = '0;
  int         rise_n = 0, fall_n = 0;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] lvl;
    logic [7:0] tog;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;
  vec_t tbl[6];

  input_conditioner #(
    .NUM_CH       (8),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .RESET_LEVEL  (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (raw_in),
    .level_o  (level_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .toggle_o (toggle_o),
    .tick_o   (tick_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      rise_or = rise_or | rise_o;
      fall_or = fall_or | fall_o;
      rise_n  = rise_n + $countones(rise_o);
      fall_n  = fall_n + $countones(fall_o);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rise_or = '0;
    fall_or = '0;
    rise_n  = 0;
    fall_n  = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Cycles (posedges) after the current point until level_o[ch] == val.
  task automatic wait_level(input int ch, input logic val, output int lat);
    lat = 999;
    for (int k = 1; k <= 30; k++) begin
      tick_clk();
      if (level_o[ch] === val) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    int   ticks;
    logic found;
    logic prev_tog;

    tbl[0] = '{raw: 8'h00, lvl: 8'h00, tog: 8'h2D, rise: 8'h00, fall: 8'h29};
    tbl[1] = '{raw: 8'hFF, lvl: 8'hFF, tog: 8'hD2, rise: 8'hFF, fall: 8'h00};
    tbl[2] = '{raw: 8'h0F, lvl: 8'h0F, tog: 8'hD2, rise: 8'h00, fall: 8'hF0};
    tbl[3] = '{raw: 8'hF0, lvl: 8'hF0, tog: 8'h22, rise: 8'hF0, fall: 8'h0F};
    tbl[4] = '{raw: 8'hAA, lvl: 8'hAA, tog: 8'h28, rise: 8'h0A, fall: 8'h50};
    tbl[5] = '{raw: 8'h55, lvl: 8'h55, tog: 8'h7D, rise: 8'h55, fall: 8'hAA};

    // Reset state, then 20 quiet cycles with the tick on every 4th cycle.
    rst    = 1'b1;
    raw_in = 8'h00;
    tick_clk();
    tick_clk();
    chk("reset_outputs", 32'({level_o, rise_o, fall_o, toggle_o}), 32'h0);
    chk("reset_tick", 32'(tick_o), 32'h0);
    rst = 1'b0;
    chk("release_tick", 32'(tick_o), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      tick_clk();
      chk("idle_outputs", 32'({level_o, rise_o, fall_o, toggle_o}), 32'h0);
      chk("idle_tick", 32'(tick_o), ((k % 4) == 3) ? 32'h1 : 32'h0);
    end

    // Clean step on PQm.
    clear_mon();
    raw_in = 8'h04;
    wait_level(CH_PQM, 1'b1, lat);
    chk_range("step_latency", lat, 11, 14);
    chk("step_rise", 32'(rise_o), 32'h04);
    chk("step_toggle", 32'(toggle_o), 32'h04);
    tick_clk();
    chk("step_rise_width", 32'(rise_o), 32'h00);
    chk("step_no_fall", 32'(fall_or), 32'h00);
    repeat (4) tick_clk();

    // Short pulse on Cm must be rejected.
    clear_mon();
    raw_in = 8'h14;
    repeat (6) tick_clk();
    raw_in = 8'h04;
    repeat (20) tick_clk();
    chk("glitch_level", 32'(level_o), 32'h04);
    chk("glitch_rise", 32'(rise_or), 32'h00);
    chk("glitch_fall", 32'(fall_or), 32'h00);

    // Bouncing set button, 3-cycle phases ending low, then settle high.
    clear_mon();
    for (int p = 0; p < 10; p++) begin
      raw_in[CH_SET] = ((p % 2) == 0);
      repeat (3) tick_clk();
    end
    chk("bounce_no_level", 32'(level_o), 32'h04);
    raw_in[CH_SET] = 1'b1;
    wait_level(CH_SET, 1'b1, lat);
    chk_range("bounce_latency", lat, 11, 14);
    repeat (20) tick_clk();
    chk("bounce_rise_count", 32'(rise_n), 32'd1);
    chk("bounce_rise_mask", 32'(rise_or), 32'h01);
    chk("bounce_fall_mask", 32'(fall_or), 32'h00);

    // PQc and Cc up, PQm down, all in the same cycle.
    raw_in = 8'h29;
    found  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick_clk();
      if (rise_o != 8'h00 || fall_o != 8'h00) begin
        found = 1'b1;
        break;
      end
    end
    chk("simul_found", 32'(found), 32'h1);
    chk("simul_rise", 32'(rise_o), 32'h28);
    chk("simul_fall", 32'(fall_o), 32'h04);
    chk("simul_level", 32'(level_o), 32'h29);
    repeat (4) tick_clk();

    // Multi-channel table.
    foreach (tbl[i]) begin
      clear_mon();
      raw_in = tbl[i].raw;
      repeat (16) tick_clk();
      chk("tbl_level", 32'(level_o), 32'(tbl[i].lvl));
      chk("tbl_toggle", 32'(toggle_o), 32'(tbl[i].tog));
      chk("tbl_rise_mask", 32'(rise_or), 32'(tbl[i].rise));
      chk("tbl_fall_mask", 32'(fall_or), 32'(tbl[i].fall));
      chk("tbl_rise_count", 32'(rise_n), 32'($countones(tbl[i].rise)));
      chk("tbl_fall_count", 32'(fall_n), 32'($countones(tbl[i].fall)));
    end

    // Reset during a debounce window on online.
    raw_in = 8'h00;
    repeat (16) tick_clk();
    chk("pre_online_level", 32'(level_o), 32'h00);
    raw_in = 8'h40;
    tick_clk();
    tick_clk();
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      if (tick_o) begin
        ticks++;
        if (ticks == 2) break;
      end
      tick_clk();
    end
    chk("online_ticks_seen", 32'(ticks), 32'd2);
    tick_clk();
    chk("online_not_yet", 32'(level_o[CH_ONLINE]), 32'h0);
    rst = 1'b1;
    tick_clk();
    chk("midreset_outputs", 32'({level_o, rise_o, fall_o, toggle_o}), 32'h0);
    chk("midreset_tick", 32'(tick_o), 32'h0);
    tick_clk();
    rst      = 1'b0;
    lat      = 999;
    prev_tog = 1'bx;
    for (int k = 1; k <= 30; k++) begin
      prev_tog = toggle_o[CH_ONLINE];
      tick_clk();
      if (level_o[CH_ONLINE] === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk_range("midreset_latency", lat, 11, 14);
    chk("midreset_toggle_before", 32'(prev_tog), 32'h0);
    chk("midreset_rise", 32'(rise_o), 32'h40);
    chk("midreset_toggle_after", 32'(toggle_o), 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
